// File: rtl/alu_issue_ctrl.sv
// Issue/collect sequencer for the 2-cycle alu: valid/ready op intake, one-stage in-flight tracking, tagged result FIFO.
// Optional ALU_ISSUE_BYPASS_EN presents the alu result directly when the FIFO is empty (latency 1).
module alu_issue_ctrl #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned TAG_W      = 5,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [2:0]       in_funct,
  input  logic             in_mod,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [2:0]       alu_funct,
  output logic             alu_mod,
  input  logic [XLEN-1:0]  alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_L = CW'(FIFO_DEPTH);

  logic             s1_valid;
  logic [TAG_W-1:0] s1_tag;

  logic [XLEN-1:0]  mem_data [FIFO_DEPTH];
  logic [TAG_W-1:0] mem_tag  [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic [CW-1:0]    occupancy;
  logic             accept;
  logic             fifo_nonempty;
  logic             push;
  logic             fifo_pop;
  logic             out_hs;

  assign alu_a     = in_a;
  assign alu_b     = in_b;
  assign alu_funct = in_funct;
  assign alu_mod   = in_mod;

  // Credit counts the in-flight op as occupied; a same-cycle pop is ignored.
  assign occupancy     = count + CW'(s1_valid);
  assign in_ready      = rst_n & ~flush & (occupancy < DEPTH_L);
  assign accept        = in_valid & in_ready;
  assign fifo_nonempty = (count != '0);
  assign out_hs        = out_valid & out_ready;
  assign fifo_pop      = fifo_nonempty & out_ready;

`ifdef ALU_ISSUE_BYPASS_EN
  logic bypass;
  assign bypass    = ~fifo_nonempty & s1_valid & ~flush;
  assign out_valid = fifo_nonempty | bypass;
  assign out_data  = bypass ? alu_result : mem_data[rd_ptr];
  assign out_tag   = bypass ? s1_tag     : mem_tag[rd_ptr];
  // A bypassed result consumed this cycle never enters the FIFO.
  assign push      = s1_valid & ~flush & ~(bypass & out_ready);
`else
  assign out_valid = fifo_nonempty;
  assign out_data  = mem_data[rd_ptr];
  assign out_tag   = mem_tag[rd_ptr];
  assign push      = s1_valid & ~flush;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_tag[i]  <= '0;
      end
    end else if (flush) begin
      s1_valid <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_tag <= in_tag;
      end
      if (push) begin
        mem_data[wr_ptr] <= alu_result;
        mem_tag[wr_ptr]  <= s1_tag;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, fifo_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
    end else if (out_hs) begin
      retired_cnt <= retired_cnt + 1'b1;
    end
  end

endmodule
